// File: rtl/prog_sequencer.sv
// prog_sequencer: runs a program-load session, streaming host words into instruction memory
// and driving the io_pads config port. Define PROG_TIMEOUT_EN to abort a stalled LOAD.
module prog_sequencer #(
    parameter int IO_PINS = 16,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_hard_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W:0]    req_words,
    input  logic [IO_PINS-1:0] req_dir,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               cfg_we,
    output logic               cfg_addr,
    output logic [IO_PINS-1:0] cfg_wdata,
    output logic               busy,
    output logic               done,
    output logic               err
);
    // state  | meaning
    // IDLE   | waiting for a session request
    // ENTER  | write programming flag = 1 (MCU held in reset, pins forced to inputs)
    // LOAD   | accept program words into memory
    // SETDIR | write the latched pin-direction mask
    // EXIT   | write programming flag = 0, pulse done
    // ABORT  | write programming flag = 0, pulse err (saved_dir untouched)
    typedef enum logic [2:0] {IDLE, ENTER, LOAD, SETDIR, EXIT, ABORT} state_t;

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_W     = (ADDR_W+1)'(1);

    state_t             state, state_nxt;
    logic [ADDR_W:0]    words_q;
    logic [ADDR_W:0]    cnt_q;
    logic [IO_PINS-1:0] dir_q;
    logic               accept;
    logic               last_word;
    logic               idle_expired;

    assign accept    = (state == LOAD) && wr_valid;
    assign last_word = (cnt_q == words_q - ONE_W);

`ifdef PROG_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] idle_q;

    // Held at zero outside LOAD, so it restarts on every LOAD entry.
    always_ff @(posedge clk or negedge rst_hard_n) begin
        if (!rst_hard_n)
            idle_q <= '0;
        else if (state != LOAD || accept)
            idle_q <= '0;
        else
            idle_q <= idle_q + TO_W'(1);
    end

    assign idle_expired = (state == LOAD) && !wr_valid && (idle_q == TO_LAST);
    assign err          = (state == ABORT);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign idle_expired   = 1'b0;
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_hard_n) begin
        if (!rst_hard_n) begin
            state     <= IDLE;
            words_q   <= '0;
            cnt_q     <= '0;
            dir_q     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state  <= state_nxt;
            mem_we <= accept;
            if (state == IDLE && req_valid) begin
                words_q <= (req_words > MAX_WORDS) ? MAX_WORDS : req_words;
                dir_q   <= req_dir;
                cnt_q   <= '0;
            end
            // Counter is one bit wider than mem_addr so a full 2**ADDR_W session never wraps.
            if (accept) begin
                mem_addr  <= cnt_q[ADDR_W-1:0];
                mem_wdata <= wr_data;
                cnt_q     <= cnt_q + ONE_W;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cfg_we    = 1'b0;
        cfg_addr  = 1'b0;
        cfg_wdata = '0;
        case (state)
            IDLE: begin
                if (req_valid)
                    state_nxt = ENTER;
            end
            ENTER: begin
                cfg_we    = 1'b1;
                cfg_wdata = IO_PINS'(1);
                state_nxt = (words_q == '0) ? SETDIR : LOAD;
            end
            LOAD: begin
                // A handshake wins over an expiring idle timer.
                if (accept && last_word)
                    state_nxt = SETDIR;
                else if (idle_expired)
                    state_nxt = ABORT;
            end
            SETDIR: begin
                cfg_we    = 1'b1;
                cfg_addr  = 1'b1;
                cfg_wdata = dir_q;
                state_nxt = EXIT;
            end
            EXIT, ABORT: begin
                cfg_we    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign wr_ready  = (state == LOAD);
    assign busy      = (state != IDLE);
    assign done      = (state == EXIT);

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: table-driven sessions plus hand-written
// multi-cycle sequences (backpressure, saturation, mid-session reset, timeout).
`timescale 1ns/1ps
module tb_prog_sequencer;
    localparam int IO_PINS = 16;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 8;

    logic               clk = 1'b0;
    logic               rst_hard_n = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [ADDR_W:0]    req_words = '0;
    logic [IO_PINS-1:0] req_dir = '0;
    logic               wr_valid = 1'b0;
    logic               wr_ready;
    logic [DATA_W-1:0]  wr_data = '0;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic               cfg_we;
    logic               cfg_addr;
    logic [IO_PINS-1:0] cfg_wdata;
    logic               busy;
    logic               done;
    logic               err;

    prog_sequencer #(
        .IO_PINS(IO_PINS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_hard_n(rst_hard_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_words(req_words), .req_dir(req_dir),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int wr_count = 0;

    always @(negedge clk) if (mem_we) wr_count++;

    typedef struct {
        logic               req_valid;
        logic [ADDR_W:0]    req_words;
        logic [IO_PINS-1:0] req_dir;
        logic               wr_valid;
        logic [DATA_W-1:0]  wr_data;
        logic               e_req_ready;
        logic               e_wr_ready;
        logic               e_busy;
        logic               e_cfg_we;
        logic               e_cfg_addr;
        logic [IO_PINS-1:0] e_cfg_wdata;
        logic               e_mem_we;
        logic [ADDR_W-1:0]  e_mem_addr;
        logic [DATA_W-1:0]  e_mem_wdata;
        logic               e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rv, input logic [ADDR_W:0] rw, input logic [IO_PINS-1:0] rd,
        input logic wv, input logic [DATA_W-1:0] wd,
        input logic rr, input logic wrr, input logic bsy,
        input logic cwe, input logic ca, input logic [IO_PINS-1:0] cwd,
        input logic mwe, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
        input logic dn);
        vec_t v;
        v.req_valid = rv;  v.req_words = rw;  v.req_dir = rd;
        v.wr_valid = wv;   v.wr_data = wd;
        v.e_req_ready = rr; v.e_wr_ready = wrr; v.e_busy = bsy;
        v.e_cfg_we = cwe;  v.e_cfg_addr = ca;  v.e_cfg_wdata = cwd;
        v.e_mem_we = mwe;  v.e_mem_addr = ma;  v.e_mem_wdata = md;
        v.e_done = dn;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [DATA_W-1:0] WA = 32'hA0A0_0001;
    localparam logic [DATA_W-1:0] WB = 32'hB0B0_0002;
    localparam logic [DATA_W-1:0] WC = 32'hC0C0_0003;

    int base;

    initial begin
        // 3-word session, then a back-to-back zero-length session
        vecs.push_back(mk(1, 3, 16'h00F0, 0, 0,               1,0,0, 0,0,0,          0,0,0,  0)); // IDLE
        vecs.push_back(mk(0, 0, 0,        1, 32'hDEAD_0000,   0,0,1, 1,0,16'h0001,   0,0,0,  0)); // ENTER
        vecs.push_back(mk(0, 0, 0,        1, WA,              0,1,1, 0,0,0,          0,0,0,  0)); // LOAD
        vecs.push_back(mk(0, 0, 0,        1, WB,              0,1,1, 0,0,0,          1,0,WA, 0));
        vecs.push_back(mk(0, 0, 0,        1, WC,              0,1,1, 0,0,0,          1,1,WB, 0));
        vecs.push_back(mk(1, 2, 16'hFFFF, 1, 32'hDEAD_0001,   0,0,1, 1,1,16'h00F0,   1,2,WC, 0)); // SETDIR
        vecs.push_back(mk(0, 0, 0,        0, 0,               0,0,1, 1,0,16'h0000,   0,0,0,  1)); // EXIT
        vecs.push_back(mk(1, 0, 16'h1234, 0, 0,               1,0,0, 0,0,0,          0,0,0,  0)); // IDLE
        vecs.push_back(mk(1, 0, 0,        1, 32'h5555_5555,   0,0,1, 1,0,16'h0001,   0,0,0,  0)); // ENTER
        vecs.push_back(mk(1, 0, 0,        1, 32'h5555_5555,   0,0,1, 1,1,16'h1234,   0,0,0,  0)); // SETDIR
        vecs.push_back(mk(0, 0, 0,        0, 0,               0,0,1, 1,0,16'h0000,   0,0,0,  1)); // EXIT
        vecs.push_back(mk(0, 0, 0,        0, 0,               1,0,0, 0,0,0,          0,0,0,  0)); // IDLE

        // Asynchronous reset with no clock edge
        #1 rst_hard_n = 1'b0;
        #1;
        chk("reset req_ready", req_ready, 1);
        chk("reset busy", busy, 0);
        chk("reset cfg_we", cfg_we, 0);
        chk("reset mem_we", mem_we, 0);
        chk("reset wr_ready", wr_ready, 0);
        chk("reset done", done, 0);
        #20 rst_hard_n = 1'b1;
        step();

        base = wr_count;
        for (int i = 0; i < vecs.size(); i++) begin
            chk($sformatf("row%0d req_ready", i), req_ready, vecs[i].e_req_ready);
            chk($sformatf("row%0d wr_ready", i), wr_ready, vecs[i].e_wr_ready);
            chk($sformatf("row%0d busy", i), busy, vecs[i].e_busy);
            chk($sformatf("row%0d cfg_we", i), cfg_we, vecs[i].e_cfg_we);
            if (vecs[i].e_cfg_we) begin
                chk($sformatf("row%0d cfg_addr", i), cfg_addr, vecs[i].e_cfg_addr);
                chk($sformatf("row%0d cfg_wdata", i), cfg_wdata, vecs[i].e_cfg_wdata);
            end
            chk($sformatf("row%0d mem_we", i), mem_we, vecs[i].e_mem_we);
            if (vecs[i].e_mem_we) begin
                chk($sformatf("row%0d mem_addr", i), mem_addr, vecs[i].e_mem_addr);
                chk($sformatf("row%0d mem_wdata", i), mem_wdata, vecs[i].e_mem_wdata);
            end
            chk($sformatf("row%0d done", i), done, vecs[i].e_done);
            chk($sformatf("row%0d err", i), err, 0);
            req_valid = vecs[i].req_valid;
            req_words = vecs[i].req_words;
            req_dir   = vecs[i].req_dir;
            wr_valid  = vecs[i].wr_valid;
            wr_data   = vecs[i].wr_data;
            step();
        end
        chk("table write count", wr_count - base, 3);

        // Backpressure: 5 idle cycles before each of 4 words
        base = wr_count;
        req_valid = 1; req_words = 4; req_dir = 16'h0A5A;
        step();
        req_valid = 0;
        step();
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < 5; g++) begin
                step();
                chk($sformatf("bp gap%0d.%0d mem_we", k, g), mem_we, 0);
                chk($sformatf("bp gap%0d.%0d wr_ready", k, g), wr_ready, 1);
            end
            wr_valid = 1; wr_data = 32'h100 + k;
            step();
            wr_valid = 0;
            chk($sformatf("bp w%0d mem_we", k), mem_we, 1);
            chk($sformatf("bp w%0d mem_addr", k), mem_addr, k);
            chk($sformatf("bp w%0d mem_wdata", k), mem_wdata, 32'h100 + k);
        end
        chk("bp setdir cfg_addr", cfg_addr, 1);
        chk("bp setdir cfg_wdata", cfg_wdata, 16'h0A5A);
        step();
        chk("bp exit done", done, 1);
        step();
        chk("bp idle req_ready", req_ready, 1);
        chk("bp write count", wr_count - base, 4);

        // Saturation: 20 requested, 16 accepted, address tops out at 15
        base = wr_count;
        req_valid = 1; req_words = 20; req_dir = 16'h8001;
        step();
        req_valid = 0; wr_valid = 1; wr_data = 32'd1000;
        step();
        for (int i = 0; i < 16; i++) begin
            step();
            chk($sformatf("sat w%0d mem_we", i), mem_we, 1);
            chk($sformatf("sat w%0d mem_addr", i), mem_addr, i);
            chk($sformatf("sat w%0d mem_wdata", i), mem_wdata, 32'd1000 + i);
            wr_data = 32'd1000 + i + 1;
        end
        chk("sat setdir cfg_addr", cfg_addr, 1);
        chk("sat setdir wr_ready", wr_ready, 0);
        step();
        chk("sat exit mem_we", mem_we, 0);
        chk("sat exit done", done, 1);
        wr_valid = 0;
        step();
        chk("sat write count", wr_count - base, 16);

        // Reset in the middle of LOAD returns to IDLE at once
        req_valid = 1; req_words = 5; req_dir = 16'h00FF;
        step();
        req_valid = 0;
        step();
        wr_valid = 1; wr_data = 32'h11;
        step();
        step();
        wr_valid = 0;
        #2 rst_hard_n = 1'b0;
        #1;
        chk("midrst req_ready", req_ready, 1);
        chk("midrst busy", busy, 0);
        chk("midrst wr_ready", wr_ready, 0);
        chk("midrst mem_we", mem_we, 0);
        chk("midrst cfg_we", cfg_we, 0);
        @(posedge clk);
        #2 rst_hard_n = 1'b1;
        step();
        req_valid = 1; req_words = 1; req_dir = 16'h0003;
        step();
        req_valid = 0;
        step();
        wr_valid = 1; wr_data = 32'h77;
        step();
        wr_valid = 0;
        chk("postrst mem_addr", mem_addr, 0);
        chk("postrst mem_wdata", mem_wdata, 32'h77);
        chk("postrst cfg_wdata", cfg_wdata, 16'h0003);
        step();
        chk("postrst done", done, 1);
        step();

`ifdef PROG_TIMEOUT_EN
        // Word 0, 7 idle cycles, word 1 on the expiring cycle, then silence until ABORT
        req_valid = 1; req_words = 3; req_dir = 16'hFFFF;
        step();
        req_valid = 0;
        step();
        wr_valid = 1; wr_data = 32'hAB00;
        step();
        wr_valid = 0;
        chk("to w0 mem_addr", mem_addr, 0);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("to wait%0d wr_ready", i), wr_ready, 1);
            step();
        end
        chk("to last-idle wr_ready", wr_ready, 1);
        wr_valid = 1; wr_data = 32'hAB01;
        step();
        wr_valid = 0;
        chk("to priority mem_we", mem_we, 1);
        chk("to priority mem_addr", mem_addr, 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("to idle%0d wr_ready", i), wr_ready, 1);
            chk($sformatf("to idle%0d err", i), err, 0);
            chk($sformatf("to idle%0d cfg_we", i), cfg_we, 0);
            step();
        end
        chk("to abort err", err, 1);
        chk("to abort cfg_we", cfg_we, 1);
        chk("to abort cfg_addr", cfg_addr, 0);
        chk("to abort cfg_wdata", cfg_wdata, 0);
        chk("to abort done", done, 0);
        step();
        chk("to idle req_ready", req_ready, 1);
        chk("to idle err", err, 0);
`else
        // Without the timeout LOAD waits indefinitely
        req_valid = 1; req_words = 1; req_dir = 16'h0C0C;
        step();
        req_valid = 0;
        step();
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("wait%0d wr_ready", i), wr_ready, 1);
            chk($sformatf("wait%0d err", i), err, 0);
            step();
        end
        wr_valid = 1; wr_data = 32'hCAFE;
        step();
        wr_valid = 0;
        chk("late word mem_wdata", mem_wdata, 32'hCAFE);
        chk("late word cfg_wdata", cfg_wdata, 16'h0C0C);
        step();
        chk("late word done", done, 1);
        chk("late word err", err, 0);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
